mdu_sequencer: RTL and testbench
================================

MDU_SEQUENCER -- requirements
Module: mdu_sequencer

Interface
REQ-001 Parameter PAR, default 32, operand width in bits; the iteration count equals PAR.
REQ-002 Parameter OPCODE_WIDTH, default 3, opcode width; encoding 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 in_valid  in  1  request present; op_code and operands are valid.
REQ-006 in_ready  out  1  sequencer can accept a request.
REQ-007 op_code  in  OPCODE_WIDTH  operation of the presented request.
REQ-008 div_by_zero  in  1  datapath flag: divisor operand is zero (combinational, valid with in_valid).
REQ-009 rem_neg  in  1  datapath flag: partial remainder is negative after the last step.
REQ-010 flush  in  1  synchronous abort of the operation in flight.
REQ-011 op_reg  out  OPCODE_WIDTH  latched opcode, drives the operand conditioning and datapath.
REQ-012 load_en  out  1  load the conditioned operands into the datapath registers.
REQ-013 step_en  out  1  perform one shift-add or non-restoring step.
REQ-014 corr_en  out  1  apply the remainder/quotient correction step.
REQ-015 hi_sel  out  1  select the high product word or the remainder as the result.
REQ-016 dz_sel  out  1  select the divide-by-zero result constants.
REQ-017 step_cnt  out  $clog2(PAR)+1  current iteration index.
REQ-018 out_valid  out  1  result available.
REQ-019 out_ready  in  1  consumer accepts the result.

Function
REQ-020 FSM states are IDLE, CALC, CORR and DONE; exactly one state is active.
REQ-021 in_ready is 1 only in IDLE; a request is accepted when in_valid and in_ready are both 1 on a clock edge.
REQ-022 On accept, op_reg latches op_code and load_en is 1 combinationally in the accept cycle; load_en is 0 in all other cycles.
REQ-023 On accept with op_code[2]=1 and div_by_zero=1, the next state is DONE with dz_sel=1; CALC is skipped.
REQ-024 On any other accept, the next state is CALC and step_cnt is set to 0.
REQ-025 In CALC, step_en=1 every cycle and step_cnt increments by 1 per cycle.
REQ-026 When step_cnt==PAR-1 in CALC, the next state is CORR if op_reg[2]=1, otherwise DONE.
REQ-027 CORR lasts exactly one cycle; corr_en = rem_neg in that cycle; the next state is DONE.
REQ-028 In DONE, out_valid=1 and all outputs hold until out_ready=1; the sequencer then returns to IDLE on that edge.
REQ-029 The sequencer does not accept a new request in the DONE/out_ready cycle; back-to-back operations have a minimum 1-cycle IDLE gap.
REQ-030 hi_sel=1 when op_reg is in {001, 010, 011, 110, 111}, and 0 otherwise; it is combinational from op_reg.
REQ-031 dz_sel is cleared on every accept; it is set only per REQ-023.
REQ-032 Latency from accept edge to out_valid: PAR cycles for multiply, PAR+1 for divide, 1 for divide-by-zero.
REQ-033 When flush=1, the next state is IDLE from any state; step_en, corr_en and out_valid are 0 from the next cycle.
REQ-034 flush takes priority over a simultaneous accept; no request is accepted while flush=1.
REQ-035 op_reg, step_cnt, hi_sel and dz_sel hold their values in IDLE until the next accept.

Reset
REQ-036 While rst_n=0, the state is IDLE, op_reg=0, step_cnt=0, dz_sel=0, out_valid=0, step_en=0, corr_en=0, and in_ready=1.
REQ-037 Reset asserted mid-CALC or in DONE returns the sequencer to IDLE immediately; the in-flight result is discarded.
REQ-038 After rst_n deasserts, the first accept is possible on the first rising edge.

Verification
REQ-039 PAR=32, MULHU accepted with out_ready=1: step_en high for 32 cycles, step_cnt 0..31, out_valid 32 cycles after accept, hi_sel=1.
REQ-040 DIV with rem_neg=1 at the end: 32 step cycles, then 1 cycle with corr_en=1, then out_valid; hi_sel=0.
REQ-041 REMU with div_by_zero=1: out_valid on the next cycle with dz_sel=1, hi_sel=1, and no step_en pulse.
REQ-042 out_ready held 0 for 5 cycles in DONE: out_valid and outputs stable and in_ready=0; IDLE on the edge after out_ready=1.
REQ-043 flush at step_cnt=10, then rst_n pulsed low mid-CALC on a second operation: IDLE with no out_valid in both cases, and a subsequent MUL completes normally.
REQ-044 in_valid held high continuously: accepts are spaced by PAR+2 cycles for multiply, and every accept coincides with a load_en pulse.

Source files
------------

// File: rtl/mdu_sequencer.sv
// mdu_sequencer: control FSM for an iterative multiply/divide unit.
// Accepts one request at a time. For a multiply it runs PAR shift-add steps.
// For a divide it runs PAR non-restoring steps followed by one correction
// cycle. A divide by zero skips the steps and goes straight to DONE with
// dz_sel set. The result is then held until the consumer accepts it.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   in_valid     request present (op_code, div_by_zero valid)
//   in_ready     high only in IDLE
//   op_code      operation: MUL MULH MULHSU MULHU DIV DIVU REM REMU
//   div_by_zero  datapath flag: divisor operand is zero
//   rem_neg      datapath flag: partial remainder negative after last step
//   flush        synchronous abort back to IDLE
//   op_reg       latched opcode for the datapath
//   load_en      load conditioned operands (accept cycle only)
//   step_en      one iteration step
//   corr_en      apply remainder/quotient correction
//   hi_sel       select high product word / remainder
//   dz_sel       select divide-by-zero constants
//   step_cnt     current iteration index
//   out_valid    result available
//   out_ready    consumer accepts the result
module mdu_sequencer #(
  parameter int unsigned PAR          = 32,
  parameter int unsigned OPCODE_WIDTH = 3,
  localparam int unsigned CW          = $clog2(PAR) + 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [OPCODE_WIDTH-1:0] op_code,
  input  logic                    div_by_zero,
  input  logic                    rem_neg,
  input  logic                    flush,
  output logic [OPCODE_WIDTH-1:0] op_reg,
  output logic                    load_en,
  output logic                    step_en,
  output logic                    corr_en,
  output logic                    hi_sel,
  output logic                    dz_sel,
  output logic [CW-1:0]           step_cnt,
  output logic                    out_valid,
  input  logic                    out_ready
);

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StCorr,
    StDone
  } state_e;

  localparam logic [CW-1:0] LastCnt = CW'(PAR - 1);

  state_e state;
  logic   accept;
  logic   is_div_op;

  // flush wins over a simultaneous request, so it also masks the accept.
  assign accept    = in_valid && (state == StIdle) && !flush;
  assign is_div_op = op_code[2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= StIdle;
      op_reg   <= '0;
      step_cnt <= '0;
      dz_sel   <= 1'b0;
    end else if (flush) begin
      state <= StIdle;
    end else begin
      unique case (state)
        StIdle: begin
          if (accept) begin
            op_reg   <= op_code;
            step_cnt <= '0;
            dz_sel   <= is_div_op && div_by_zero;
            state    <= (is_div_op && div_by_zero) ? StDone : StCalc;
          end
        end
        StCalc: begin
          // Count holds at the last index once the iterations are done.
          if (step_cnt == LastCnt) begin
            state <= op_reg[2] ? StCorr : StDone;
          end else begin
            step_cnt <= step_cnt + CW'(1);
          end
        end
        StCorr: state <= StDone;
        StDone: begin
          if (out_ready) begin
            state <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

  // Remaining outputs decode directly from the state register.
  assign in_ready  = (state == StIdle);
  assign load_en   = accept;
  assign step_en   = (state == StCalc);
  assign corr_en   = (state == StCorr) && rem_neg;
  assign out_valid = (state == StDone);

  // High word for MULH/MULHSU/MULHU, remainder for REM/REMU.
  assign hi_sel = op_reg[2] ? op_reg[1] : (op_reg[1:0] != 2'b00);

endmodule

// File: tb/tb_mdu_sequencer.sv
module tb_mdu_sequencer;

  localparam int unsigned PAR = 32;
  localparam int unsigned OW  = 3;
  localparam int unsigned CW  = $clog2(PAR) + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [OW-1:0] op_code;
  logic          div_by_zero;
  logic          rem_neg;
  logic          flush;
  logic [OW-1:0] op_reg;
  logic          load_en;
  logic          step_en;
  logic          corr_en;
  logic          hi_sel;
  logic          dz_sel;
  logic [CW-1:0] step_cnt;
  logic          out_valid;
  logic          out_ready;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mdu_sequencer #(
    .PAR          (PAR),
    .OPCODE_WIDTH (OW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .op_code     (op_code),
    .div_by_zero (div_by_zero),
    .rem_neg     (rem_neg),
    .flush       (flush),
    .op_reg      (op_reg),
    .load_en     (load_en),
    .step_en     (step_en),
    .corr_en     (corr_en),
    .hi_sel      (hi_sel),
    .dz_sel      (dz_sel),
    .step_cnt    (step_cnt),
    .out_valid   (out_valid),
    .out_ready   (out_ready)
  );

  // Reference: which ops return the high word / remainder.
  function automatic logic exp_hi(input logic [2:0] op);
    return op inside {3'b001, 3'b010, 3'b011, 3'b110, 3'b111};
  endfunction

  // One complete transaction checked against the op-level timeline:
  // accept, N steps, optional correction, DONE held rdy_wait extra cycles.
  task automatic run_op(input logic [2:0] op, input logic dbz, input logic rn,
                        input int rdy_wait);
    int  n_steps;
    logic has_corr;
    logic exp_dz;
    exp_dz   = op[2] && dbz;
    n_steps  = exp_dz ? 0 : PAR;
    has_corr = op[2] && !dbz;
    @(negedge clk);
    in_valid = 1'b1; op_code = op; div_by_zero = dbz; out_ready = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || load_en !== 1'b1) begin
      errors++;
      $display("FAIL accept op=%0d: in_ready=%b load_en=%b, required 1 1", op, in_ready, load_en);
    end
    @(posedge clk);
    #1 in_valid = 1'b0; div_by_zero = 1'b0; op_code = 3'($urandom_range(0, 7));
    for (int k = 0; k < n_steps; k++) begin
      @(negedge clk); #1;
      checks++;
      if (step_en !== 1'b1 || step_cnt !== CW'(k) || out_valid !== 1'b0 || load_en !== 1'b0
          || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL step op=%0d k=%0d: step_en=%b step_cnt=%0d out_valid=%b load_en=%b in_ready=%b, required 1 %0d 0 0 0",
                 op, k, step_en, step_cnt, out_valid, load_en, in_ready, k);
      end
    end
    if (has_corr) begin
      @(negedge clk);
      rem_neg = rn;
      #1;
      checks++;
      if (corr_en !== rn || step_en !== 1'b0 || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL corr op=%0d: corr_en=%b step_en=%b out_valid=%b, required %b 0 0",
                 op, corr_en, step_en, out_valid, rn);
      end
    end
    for (int w = 0; w <= rdy_wait; w++) begin
      @(negedge clk);
      rem_neg = $urandom_range(0, 1);
      #1;
      checks++;
      if (out_valid !== 1'b1 || op_reg !== op || hi_sel !== exp_hi(op) || dz_sel !== exp_dz
          || in_ready !== 1'b0 || step_en !== 1'b0 || corr_en !== 1'b0) begin
        errors++;
        $display("FAIL done op=%0d w=%0d: out_valid=%b op_reg=%0d hi_sel=%b dz_sel=%b in_ready=%b step_en=%b corr_en=%b, required 1 %0d %b %b 0 0 0",
                 op, w, out_valid, op_reg, hi_sel, dz_sel, in_ready, step_en, corr_en,
                 op, exp_hi(op), exp_dz);
      end
      if (w == rdy_wait) out_ready = 1'b1;
    end
    @(negedge clk);
    out_ready = 1'b0; rem_neg = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || op_reg !== op || hi_sel !== exp_hi(op)
        || dz_sel !== exp_dz) begin
      errors++;
      $display("FAIL idle after op=%0d: out_valid=%b in_ready=%b op_reg=%0d hi_sel=%b dz_sel=%b, required 0 1 %0d %b %b",
               op, out_valid, in_ready, op_reg, hi_sel, dz_sel, op, exp_hi(op), exp_dz);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; op_code = '0; div_by_zero = 1'b0; rem_neg = 1'b0;
    flush = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1 || op_reg !== '0 || step_cnt !== '0 || dz_sel !== 1'b0
        || out_valid !== 1'b0 || step_en !== 1'b0 || corr_en !== 1'b0) begin
      errors++;
      $display("FAIL reset: in_ready=%b op_reg=%0d step_cnt=%0d dz_sel=%b out_valid=%b step_en=%b corr_en=%b, required 1 0 0 0 0 0 0",
               in_ready, op_reg, step_cnt, dz_sel, out_valid, step_en, corr_en);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    run_op(3'b000, 1'b0, 1'b0, 0);  // MUL right after reset release
    run_op(3'b011, 1'b0, 1'b0, 0);  // MULHU
    run_op(3'b100, 1'b0, 1'b1, 0);  // DIV with rem_neg at the end
    run_op(3'b111, 1'b1, 1'b0, 0);  // REMU divide by zero
    run_op(3'b001, 1'b1, 1'b0, 0);  // MULH ignores div_by_zero
  endtask

  task automatic test_backpressure();
    run_op(3'b110, 1'b0, 1'b0, 5);
  endtask

  task automatic test_random();
    for (int i = 0; i < 12; i++) begin
      run_op(3'($urandom_range(0, 7)), ($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)),
             int'($urandom_range(0, 3)));
    end
  endtask

  task automatic test_flush();
    // Flush in IDLE beats a simultaneous request.
    @(negedge clk);
    in_valid = 1'b1; op_code = 3'b000; flush = 1'b1;
    #1;
    checks++;
    if (load_en !== 1'b0) begin
      errors++;
      $display("FAIL flush_vs_accept: load_en=%b, required 0", load_en);
    end
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || step_en !== 1'b0) begin
      errors++;
      $display("FAIL flush_no_accept: in_ready=%b step_en=%b, required 1 0", in_ready, step_en);
    end
    // Flush mid-calculation at step_cnt 10.
    @(negedge clk);
    in_valid = 1'b1; op_code = 3'b010;
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k < 10; k++) @(negedge clk);
    #1;
    checks++;
    if (step_cnt !== CW'(10) || step_en !== 1'b1) begin
      errors++;
      $display("FAIL flush_pre: step_cnt=%0d step_en=%b, required 10 1", step_cnt, step_en);
    end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    for (int k = 0; k < PAR + 4; k++) begin
      #1;
      checks++;
      if (in_ready !== 1'b1 || step_en !== 1'b0 || corr_en !== 1'b0 || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL flush_idle k=%0d: in_ready=%b step_en=%b corr_en=%b out_valid=%b, required 1 0 0 0",
                 k, in_ready, step_en, corr_en, out_valid);
      end
      @(negedge clk);
    end
  endtask

  task automatic check_reset_state(input string tag);
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || step_en !== 1'b0 || op_reg !== '0
        || step_cnt !== '0 || dz_sel !== 1'b0) begin
      errors++;
      $display("FAIL %s: in_ready=%b out_valid=%b step_en=%b op_reg=%0d step_cnt=%0d dz_sel=%b, required 1 0 0 0 0 0",
               tag, in_ready, out_valid, step_en, op_reg, step_cnt, dz_sel);
    end
  endtask

  task automatic test_reset_midop();
    // Reset during CALC of a DIV.
    @(negedge clk);
    in_valid = 1'b1; op_code = 3'b100;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    check_reset_state("reset_mid_calc");
    @(negedge clk);
    rst_n = 1'b1;
    // Reset while a divide-by-zero result sits in DONE.
    in_valid = 1'b1; op_code = 3'b101; div_by_zero = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; div_by_zero = 1'b0;
    rst_n = 1'b0;
    check_reset_state("reset_in_done");
    @(negedge clk);
    rst_n = 1'b1;
    run_op(3'b000, 1'b0, 1'b0, 0);
  endtask

  task automatic test_back_to_back();
    int accepts[$];
    @(negedge clk);
    in_valid = 1'b1; op_code = 3'b000; out_ready = 1'b1;
    for (int c = 0; c < 3 * (PAR + 2) + 3; c++) begin
      #1;
      if (load_en === 1'b1) accepts.push_back(c);
      if (load_en === 1'b1 && in_ready !== 1'b1) begin
        errors++;
        $display("FAIL b2b load_without_ready cycle=%0d", c);
      end
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b0;
    checks++;
    if (accepts.size() != 4) begin
      errors++;
      $display("FAIL b2b accept_count: got %0d, required 4", accepts.size());
    end
    for (int i = 1; i < accepts.size(); i++) begin
      checks++;
      if (accepts[i] - accepts[i-1] != PAR + 2) begin
        errors++;
        $display("FAIL b2b spacing %0d: got %0d, required %0d", i,
                 accepts[i] - accepts[i-1], PAR + 2);
      end
    end
    // Drain any transaction still in flight.
    repeat (PAR + 4) @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_random();
    test_flush();
    test_reset_midop();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
